// File: rtl/count_op_sequencer.sv
// Programmable op scheduler for the BCD counter datapath: replays a small
// {op, repeat} program as one-cycle op strobes, paced by a tick divider or single steps.
module count_op_sequencer #(
   parameter int DEPTH    = 8,
   parameter int PTR_W    = 3,
   parameter int TICK_DIV = 50000000,
   parameter int DIV_W    = 26
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [PTR_W-1:0] wr_addr,
   input  logic [1:0]       wr_op,
   input  logic [3:0]       wr_rep,
   input  logic             start,
   input  logic             stop,
   input  logic             step_mode,
   input  logic             step_req,
   input  logic             loop_en,
   input  logic             halt_en,
   input  logic [3:0]       halt_value,
   input  logic [3:0]       count_in,
   output logic [1:0]       op,
   output logic             op_valid,
   output logic             busy,
   output logic             done,
   output logic             halted,
   output logic [PTR_W-1:0] pc,
   output logic [3:0]       rep_left
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT_TICK, S_ISSUE, S_DONE, S_HALT
   } state_t;

   typedef struct packed {
      logic [1:0] op;
      logic [3:0] rep;
   } entry_t;

   localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [PTR_W-1:0] PC_LAST   = PTR_W'(DEPTH - 1);

   state_t           state_q, state_d;
   entry_t           prog_q [DEPTH];
   entry_t           prog_d [DEPTH];
   logic [PTR_W-1:0] pc_q, pc_d;
   logic [3:0]       rep_left_q, rep_left_d;
   logic [DIV_W-1:0] tick_q, tick_d;
   logic [1:0]       op_q, op_d;
   entry_t           cur;
   logic             editable;

   assign cur      = prog_q[pc_q];
   assign editable = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_HALT);

   // The program can only change while nothing is executing from it.
   always_comb begin
      prog_d = prog_q;
      if (wr_en && editable) begin
         prog_d[wr_addr] = '{op: wr_op, rep: wr_rep};
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      rep_left_d = rep_left_q;
      tick_d     = tick_q;
      op_d       = op_q;
      if (stop) begin
         if (state_q != S_IDLE) state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_HALT: begin
               if (start) begin
                  state_d = S_FETCH;
                  pc_d    = '0;
               end
            end
            S_FETCH: begin
               if (cur.rep != 4'd0) begin
                  rep_left_d = cur.rep;
                  tick_d     = '0;
                  state_d    = S_WAIT_TICK;
               end else if (loop_en && (pc_q != '0)) begin
                  pc_d = '0;
               end else begin
                  state_d = S_DONE;
               end
            end
            S_WAIT_TICK: begin
               // op is loaded on entry to ISSUE so it is valid with the strobe and held after.
               if (halt_en && (count_in == halt_value)) begin
                  state_d = S_HALT;
               end else if (step_mode) begin
                  tick_d = '0;
                  if (step_req) begin
                     state_d = S_ISSUE;
                     op_d    = cur.op;
                  end
               end else if (tick_q == TICK_LAST) begin
                  state_d = S_ISSUE;
                  op_d    = cur.op;
               end else begin
                  tick_d = tick_q + DIV_W'(1);
               end
            end
            S_ISSUE: begin
               rep_left_d = rep_left_q - 4'd1;
               if (rep_left_q > 4'd1) begin
                  tick_d  = '0;
                  state_d = S_WAIT_TICK;
               end else if (pc_q == PC_LAST) begin
                  if (loop_en) begin
                     pc_d    = '0;
                     state_d = S_FETCH;
                  end else begin
                     state_d = S_DONE;
                  end
               end else begin
                  pc_d    = pc_q + PTR_W'(1);
                  state_d = S_FETCH;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         rep_left_q <= '0;
         tick_q     <= '0;
         op_q       <= '0;
         // NOTE: the program store is reset on purpose; a cleared entry is an end marker.
         for (int i = 0; i < DEPTH; i++) prog_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         rep_left_q <= rep_left_d;
         tick_q     <= tick_d;
         op_q       <= op_d;
         prog_q     <= prog_d;
      end
   end

   assign op       = op_q;
   assign op_valid = (state_q == S_ISSUE);
   assign busy     = (state_q == S_FETCH) || (state_q == S_WAIT_TICK) || (state_q == S_ISSUE);
   assign done     = (state_q == S_DONE);
   assign halted   = (state_q == S_HALT);
   assign pc       = pc_q;
   assign rep_left = rep_left_q;

endmodule

// File: tb/tb_count_op_sequencer.sv
// Self-checking bench for count_op_sequencer with TICK_DIV=4: cycle tables, run
// pattern table, and hand-written sequences for halt, step, hazards and reset.
module tb_count_op_sequencer;

   localparam int DEPTH = 8;
   localparam int PTR_W = 3;
   localparam int TDIV  = 4;
   localparam int DIV_W = 3;

   logic             CLK = 1'b0;
   logic             reset = 1'b1;
   logic             wr_en = 1'b0;
   logic [PTR_W-1:0] wr_addr = '0;
   logic [1:0]       wr_op = '0;
   logic [3:0]       wr_rep = '0;
   logic             start = 1'b0, stop = 1'b0;
   logic             step_mode = 1'b0, step_req = 1'b0;
   logic             loop_en = 1'b0, halt_en = 1'b0;
   logic [3:0]       halt_value = 4'd5;
   logic [3:0]       count_in = 4'd0;
   logic [1:0]       op;
   logic             op_valid, busy, done, halted;
   logic [PTR_W-1:0] pc;
   logic [3:0]       rep_left;

   count_op_sequencer #(.DEPTH(DEPTH), .PTR_W(PTR_W), .TICK_DIV(TDIV), .DIV_W(DIV_W)) dut (
      .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_op(wr_op),
      .wr_rep(wr_rep), .start(start), .stop(stop), .step_mode(step_mode),
      .step_req(step_req), .loop_en(loop_en), .halt_en(halt_en),
      .halt_value(halt_value), .count_in(count_in), .op(op), .op_valid(op_valid),
      .busy(busy), .done(done), .halted(halted), .pc(pc), .rep_left(rep_left)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int               cyc;
      logic [1:0]       op;
      logic [PTR_W-1:0] pc;
   } exp_t;

   typedef struct {
      logic start;
      logic busy;
      logic done;
      logic valid;
   } vec_t;

   typedef struct {
      logic [1:0] op;
      logic [3:0] rep;
   } pat_t;

   exp_t       sb[$];
   int         n_tests = 0;
   int         n_fail = 0;
   int         cyc = 0;
   logic       pend = 1'b0;
   logic [3:0] pend_val = '0;
   vec_t       vecs[18];
   pat_t       pats[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [3:0] bcd_next(input logic [3:0] c, input logic [1:0] o);
      case (o)
         2'b00:   return (c == 4'd9) ? 4'd0 : c + 4'd1;
         2'b01:   return (c >= 4'd8) ? c - 4'd8 : c + 4'd2;
         2'b10:   return (c == 4'd0) ? 4'd9 : c - 4'd1;
         default: return c;
      endcase
   endfunction

   // One clock; observe #1 after the edge. Strobes are scored and fed to the counter model,
   // whose new value appears one cycle later as from a registered datapath.
   task automatic step();
      exp_t e;
      @(posedge CLK);
      #1;
      cyc++;
      if (pend) begin
         count_in = pend_val;
         pend     = 1'b0;
      end
      if (op_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_strobe: op_valid=1 op=%0d pc=%0d at cycle %0d, expected none",
                     op, pc, cyc);
         end else begin
            e = sb.pop_front();
            check("strobe_op", 32'(op), 32'(e.op));
            check("strobe_pc", 32'(pc), 32'(e.pc));
            if (e.cyc >= 0) check("strobe_cycle", 32'(cyc), 32'(e.cyc));
         end
         pend     = 1'b1;
         pend_val = bcd_next(count_in, op);
      end
   endtask

   task automatic expect_strobe(input int c, input logic [1:0] o, input logic [PTR_W-1:0] p);
      exp_t e;
      e.cyc = c;
      e.op  = o;
      e.pc  = p;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      sb.delete();
      reset = 1'b1;
      wr_en = 1'b0; start = 1'b0; stop = 1'b0; step_mode = 1'b0; step_req = 1'b0;
      loop_en = 1'b0; halt_en = 1'b0; count_in = 4'd0; pend = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic write_entry(input logic [PTR_W-1:0] a, input logic [1:0] o, input logic [3:0] r);
      wr_en = 1'b1; wr_addr = a; wr_op = o; wr_rep = r;
      step();
      wr_en = 1'b0;
   endtask

   task automatic pulse_start();
      cyc   = 0;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_not_busy(input int max, input string name);
      int n = 0;
      while (busy && n < max) begin
         step();
         n++;
      end
      check(name, 32'(busy), 32'd0);
   endtask

   task automatic wait_sb_empty(input int max, input string name);
      int n = 0;
      while (sb.size() != 0 && n < max) begin
         step();
         n++;
      end
      check(name, 32'(sb.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_op"},       32'(op),       32'd0);
      check({tag, "_op_valid"}, 32'(op_valid), 32'd0);
      check({tag, "_busy"},     32'(busy),     32'd0);
      check({tag, "_done"},     32'(done),     32'd0);
      check({tag, "_halted"},   32'(halted),   32'd0);
      check({tag, "_pc"},       32'(pc),       32'd0);
      check({tag, "_rep_left"}, 32'(rep_left), 32'd0);
   endtask

   initial begin
      // Cycle table for the basic run: record i is driven before edge i+1 and checked after it.
      for (int i = 0; i < 18; i++) begin
         vecs[i].start = (i == 0);
         vecs[i].busy  = (i + 1 <= 17);
         vecs[i].done  = (i + 1 >= 18);
         vecs[i].valid = (i + 1 == 6) || (i + 1 == 11) || (i + 1 == 16);
      end
      pats[0] = '{op: 2'b01, rep: 4'd1};
      pats[1] = '{op: 2'b10, rep: 4'd2};
      pats[2] = '{op: 2'b11, rep: 4'd1};
      pats[3] = '{op: 2'b01, rep: 4'd3};
      pats[4] = '{op: 2'b10, rep: 4'd15};

      step();
      do_reset();
      check_reset_outputs("reset");

      // Basic run: e0={00,3}, e1 end marker.
      write_entry(3'd0, 2'b00, 4'd3);
      expect_strobe(6, 2'b00, 3'd0);
      expect_strobe(11, 2'b00, 3'd0);
      expect_strobe(16, 2'b00, 3'd0);
      cyc = 0;
      for (int i = 0; i < 18; i++) begin
         start = vecs[i].start;
         step();
         start = 1'b0;
         check("basic_busy",  32'(busy),     32'(vecs[i].busy));
         check("basic_done",  32'(done),     32'(vecs[i].done));
         check("basic_valid", 32'(op_valid), 32'(vecs[i].valid));
         if (cyc == 17) check("basic_fetch_pc", 32'(pc), 32'd1);
      end
      check("basic_sb_drained", 32'(sb.size()), 32'd0);

      // Single-entry run patterns.
      for (int p = 0; p < 5; p++) begin
         do_reset();
         write_entry(3'd0, pats[p].op, pats[p].rep);
         for (int k = 0; k < int'(pats[p].rep); k++) expect_strobe(2 + TDIV + k * (TDIV + 1), pats[p].op, 3'd0);
         pulse_start();
         wait_not_busy(200, "pat_timeout");
         check("pat_done",     32'(done),      32'd1);
         check("pat_op_held",  32'(op),        32'(pats[p].op));
         check("pat_rep_left", 32'(rep_left),  32'd0);
         check("pat_pc",       32'(pc),        32'd1);
         check("pat_drained",  32'(sb.size()), 32'd0);
      end

      // Halt on match: counter starts at 3, one add-two makes it 5.
      do_reset();
      write_entry(3'd0, 2'b01, 4'd5);
      halt_en = 1'b1; halt_value = 4'd5; count_in = 4'd3;
      expect_strobe(6, 2'b01, 3'd0);
      pulse_start();
      while (cyc < 7) step();
      check("halt_not_yet", 32'(halted), 32'd0);
      step();
      check("halt_halted",   32'(halted),   32'd1);
      check("halt_busy",     32'(busy),     32'd0);
      check("halt_rep_left", 32'(rep_left), 32'd4);
      repeat (30) step();
      check("halt_stays",   32'(halted),    32'd1);
      check("halt_drained", 32'(sb.size()), 32'd0);
      halt_en = 1'b0;

      // Full program, no loop: 8 strobes walking pc 0..7.
      do_reset();
      for (int a = 0; a < DEPTH; a++) write_entry(3'(a), 2'b10, 4'd1);
      for (int a = 0; a < DEPTH; a++) expect_strobe(6 + a * (TDIV + 2), 2'b10, 3'(a));
      pulse_start();
      wait_not_busy(200, "full_timeout");
      check("full_done",    32'(done),      32'd1);
      check("full_drained", 32'(sb.size()), 32'd0);

      // Same program looping; stop lands during the 12th ISSUE (pc 3).
      loop_en = 1'b1;
      for (int a = 0; a < 12; a++) expect_strobe(6 + a * (TDIV + 2), 2'b10, 3'(a % DEPTH));
      pulse_start();
      wait_sb_empty(200, "loop_timeout");
      check("loop_in_issue", 32'(op_valid), 32'd1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stop_valid",    32'(op_valid), 32'd0);
      check("stop_busy",     32'(busy),     32'd0);
      check("stop_done",     32'(done),     32'd0);
      check("stop_halted",   32'(halted),   32'd0);
      check("stop_pc",       32'(pc),       32'd3);
      check("stop_rep_left", 32'(rep_left), 32'd1);
      repeat (20) step();
      check("stop_quiet", 32'(busy), 32'd0);

      // End marker with loop_en: FETCH at pc 1 rewinds to 0, strobes 7 cycles apart.
      do_reset();
      write_entry(3'd0, 2'b11, 4'd1);
      loop_en = 1'b1;
      expect_strobe(6, 2'b11, 3'd0);
      expect_strobe(13, 2'b11, 3'd0);
      expect_strobe(20, 2'b11, 3'd0);
      pulse_start();
      wait_sb_empty(100, "marker_loop_timeout");
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("marker_stop_busy", 32'(busy), 32'd0);

      // Single step mode.
      do_reset();
      write_entry(3'd0, 2'b00, 4'd2);
      step_mode = 1'b1;
      pulse_start();
      repeat (50) step();
      check("step_wait_busy",  32'(busy),     32'd1);
      check("step_wait_valid", 32'(op_valid), 32'd0);
      expect_strobe(52, 2'b00, 3'd0);
      step_req = 1'b1;
      step();
      check("step_issue1", 32'(op_valid), 32'd1);
      step();
      step_req = 1'b0;
      check("step_ignored_a", 32'(op_valid), 32'd0);
      step();
      check("step_ignored_b", 32'(op_valid), 32'd0);
      expect_strobe(55, 2'b00, 3'd0);
      step_req = 1'b1;
      step();
      step_req = 1'b0;
      check("step_issue2", 32'(op_valid), 32'd1);
      step();
      step();
      check("step_done",    32'(done),      32'd1);
      check("step_drained", 32'(sb.size()), 32'd0);
      step_mode = 1'b0;

      // Writes and start while busy are ignored.
      do_reset();
      write_entry(3'd0, 2'b01, 4'd2);
      expect_strobe(6, 2'b01, 3'd0);
      expect_strobe(11, 2'b01, 3'd0);
      pulse_start();
      step();
      write_entry(3'd0, 2'b11, 4'd9);
      write_entry(3'd1, 2'b00, 4'd3);
      while (cyc < 7) step();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_not_busy(100, "hazard_timeout");
      check("hazard_done", 32'(done), 32'd1);
      check("hazard_pc",   32'(pc),   32'd1);
      expect_strobe(6, 2'b01, 3'd0);
      expect_strobe(11, 2'b01, 3'd0);
      pulse_start();
      wait_not_busy(100, "hazard_rerun_timeout");
      check("hazard_rerun_done", 32'(done),      32'd1);
      check("hazard_drained",    32'(sb.size()), 32'd0);

      // Reset mid-run clears outputs and the program.
      do_reset();
      write_entry(3'd0, 2'b10, 4'd2);
      expect_strobe(6, 2'b10, 3'd0);
      pulse_start();
      while (cyc < 8) step();
      check("midrun_busy", 32'(busy), 32'd1);
      do_reset();
      check_reset_outputs("midrun_reset");
      pulse_start();
      check("cleared_fetch_busy", 32'(busy), 32'd1);
      step();
      check("cleared_done", 32'(done), 32'd1);
      repeat (10) step();

      // Empty program with loop_en: FETCH then DONE, no strobes.
      do_reset();
      loop_en = 1'b1;
      pulse_start();
      check("empty_fetch_busy", 32'(busy), 32'd1);
      step();
      check("empty_done",  32'(done), 32'd1);
      check("empty_busy",  32'(busy), 32'd0);
      repeat (10) step();
      check("empty_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
